rgmii_rx_framer: RTL and testbench

//  Receive-side Ethernet framer; counterpart of the transmit packet path. Sits in the
//  phy_rx_demux_clk domain after the RGMII DDR input demux. Strips preamble/SFD,

---
 rtl/rgmii_rx_framer.sv | 183 ++++++++++++++++++
 tb/tb_rgmii_rx_framer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: strips preamble/SFD, checks length and FCS, emits DA..payload
// with an end-of-frame status strobe. Define RGMII_RX_MAC_FILTER_EN for destination filtering.
module rgmii_rx_framer #(
  parameter int          MIN_LEN  = 64,
  parameter int          MAX_LEN  = 1518,
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic [1:0]  rx_ctl,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic [2:0]  out_err,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
);
  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;
  localparam logic [31:0] CRC_RES = 32'hDEBB20E3;
  localparam int CW = $clog2(MAX_LEN + 2);
`ifdef RGMII_RX_MAC_FILTER_EN
  localparam int HOLD = 6;
`else
  localparam int HOLD = 0;
`endif

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  logic [7:0]      byte_q;
  logic            dv_q, er_q;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     crc_q, crc_d;
  logic [3:0][7:0] dl_q, dl_d;
  logic            rxer_q, rxer_d;
  logic            vld_d, sof_d, eof_d, kill;
  logic [7:0]      dat_d;
  logic [2:0]      err_d;
  logic            cnt_eof;
  logic [2:0]      cnt_err;
  logic [15:0]     ok_q, bad_q;

  // Output stage pipe; depth > 0 only when DA filtering must be able to retract bytes.
  logic [HOLD:0]      vld_pipe_q, sof_pipe_q, eof_pipe_q;
  logic [HOLD:0][7:0] dat_pipe_q;
  logic [HOLD:0][2:0] err_pipe_q;

`ifdef RGMII_RX_MAC_FILTER_EN
  logic [47:0] da_q, da_d, da_full;
  assign da_full = {da_q[39:0], byte_q};
  always_ff @(posedge clk) begin
    if (reset) da_q <= '0;
    else       da_q <= da_d;
  end
  assign cnt_eof = eof_pipe_q[HOLD-1];
  assign cnt_err = err_pipe_q[HOLD-1];
`else
  assign cnt_eof = eof_d;
  assign cnt_err = err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    dl_d    = dl_q;
    rxer_d  = rxer_q;
    vld_d   = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    dat_d   = dl_q[3];
    err_d   = 3'b000;
    kill    = 1'b0;
`ifdef RGMII_RX_MAC_FILTER_EN
    da_d    = da_q;
`endif
    case (state_q)
      IDLE, PRE: begin
        cnt_d  = '0;
        crc_d  = '1;
        rxer_d = 1'b0;
        if (!dv_q)                 state_d = IDLE;
        else if (byte_q == 8'h55)  state_d = PRE;
        else if (byte_q == 8'hD5)  state_d = DATA;
        else                       state_d = DROP;
      end
      DATA: begin
        if (dv_q) begin
          cnt_d  = cnt_q + 1'b1;
          crc_d  = crc_byte(crc_q, byte_q);
          dl_d   = {dl_q[2:0], byte_q};
          rxer_d = rxer_q | er_q;
`ifdef RGMII_RX_MAC_FILTER_EN
          if (cnt_q < CW'(6)) da_d = {da_q[39:0], byte_q};
`endif
          if (cnt_q == CW'(MAX_LEN)) begin
            eof_d   = 1'b1;
            err_d   = {1'b0, 1'b1, rxer_q | er_q};
            state_d = DROP;
          end else if (cnt_q >= CW'(4)) begin
            // oldest of the four buffered bytes is known not to be FCS
            vld_d = 1'b1;
            sof_d = (cnt_q == CW'(4));
          end
`ifdef RGMII_RX_MAC_FILTER_EN
          if (cnt_q == CW'(5) && da_full != MAC_ADDR && da_full != 48'hFFFF_FFFF_FFFF) begin
            vld_d   = 1'b0;
            sof_d   = 1'b0;
            kill    = 1'b1;
            state_d = DROP;
          end
`endif
        end else begin
          eof_d   = 1'b1;
          err_d   = {crc_q != CRC_RES, (cnt_q < CW'(MIN_LEN)) || (cnt_q > CW'(MAX_LEN)), rxer_q};
          state_d = IDLE;
        end
      end
      default: if (!dv_q) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_q     <= '0;
      dv_q       <= 1'b0;
      er_q       <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      crc_q      <= '1;
      dl_q       <= '0;
      rxer_q     <= 1'b0;
      vld_pipe_q <= '0;
      sof_pipe_q <= '0;
      eof_pipe_q <= '0;
      dat_pipe_q <= '0;
      err_pipe_q <= '0;
      ok_q       <= '0;
      bad_q      <= '0;
    end else begin
      byte_q  <= rx_data;
      dv_q    <= rx_ctl[0];
      er_q    <= rx_ctl[0] ^ rx_ctl[1];
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      dl_q    <= dl_d;
      rxer_q  <= rxer_d;
      vld_pipe_q[0] <= vld_d;
      sof_pipe_q[0] <= sof_d;
      eof_pipe_q[0] <= eof_d;
      dat_pipe_q[0] <= dat_d;
      err_pipe_q[0] <= err_d;
      for (int i = 1; i <= HOLD; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1] & ~kill;
        sof_pipe_q[i] <= sof_pipe_q[i-1] & ~kill;
        eof_pipe_q[i] <= eof_pipe_q[i-1];
        dat_pipe_q[i] <= dat_pipe_q[i-1];
        err_pipe_q[i] <= err_pipe_q[i-1];
      end
      if (cnt_eof) begin
        if (cnt_err == 3'b000) ok_q  <= ok_q + 16'd1;
        else                   bad_q <= bad_q + 16'd1;
      end
    end
  end

  assign out_data   = dat_pipe_q[HOLD];
  assign out_valid  = vld_pipe_q[HOLD];
  assign out_sof    = sof_pipe_q[HOLD];
  assign out_eof    = eof_pipe_q[HOLD];
  assign out_err    = err_pipe_q[HOLD];
  assign frames_ok  = ok_q;
  assign frames_bad = bad_q;
endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Scoreboard bench for rgmii_rx_framer: frames are modelled as byte lists; expected
// payload bytes and end-of-frame status are queued when a frame is sent.
module tb_rgmii_rx_framer;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic [1:0]  rx_ctl;
  logic [7:0]  out_data;
  logic        out_valid, out_sof, out_eof;
  logic [2:0]  out_err;
  logic [15:0] frames_ok, frames_bad;

  rgmii_rx_framer dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ctl(rx_ctl),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .out_err(out_err), .frames_ok(frames_ok), .frames_bad(frames_bad)
  );

  always #4 clk = ~clk;

  typedef struct {
    bit       eof;
    bit [7:0] data;
    bit       sof;
    bit [2:0] err;
    int       ok;
    int       bad;
  } exp_t;

  exp_t     sb[$];
  exp_t     cur;
  bit [7:0] fr[$];
  int       total = 0, bad = 0;
  int       exp_ok = 0, exp_bad = 0;

  task automatic chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every presented byte or eof must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && (out_valid || out_eof)) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_output valid=%0b eof=%0b data=%0h", out_valid, out_eof, out_data);
      end else begin
        cur = sb.pop_front();
        chk("out_kind_eof", int'(out_eof), int'(cur.eof));
        if (cur.eof) begin
          chk("eof_without_valid", int'(out_valid), 0);
          chk("out_err", int'(out_err), int'(cur.err));
          chk("frames_ok", int'(frames_ok), cur.ok);
          chk("frames_bad", int'(frames_bad), cur.bad);
        end else begin
          chk("out_data", int'(out_data), int'(cur.data));
          chk("out_sof", int'(out_sof), int'(cur.sof));
        end
      end
    end
  end

  function automatic bit [31:0] fcs32(int n);
    bit [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++)
        c = (c >> 1) ^ ((c[0] ^ fr[i][j]) ? 32'hEDB88320 : 32'h0);
    return ~c;
  endfunction

  // kind 0: incrementing payload, 1: random payload
  task automatic build(int n, int kind);
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(kind == 0 ? 8'(i) : 8'($urandom));
  endtask

  task automatic add_fcs(bit corrupt);
    bit [31:0] f;
    f = fcs32(fr.size());
    for (int i = 0; i < 4; i++) fr.push_back(f[8*i +: 8]);
    if (corrupt) fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h01;
  endtask

  task automatic drv(bit dv, bit er, logic [7:0] d);
    @(negedge clk);
    rx_data = d;
    rx_ctl  = {dv ^ er, dv};
  endtask

  task automatic push_byte(bit [7:0] d, bit s);
    exp_t e;
    e = '{eof: 1'b0, data: d, sof: s, err: 3'b000, ok: 0, bad: 0};
    sb.push_back(e);
  endtask

  // Model: frame minus trailing FCS is delivered; oversize frames are cut at MAX_LEN+1 bytes.
  task automatic send_frame(int pre, int er_idx, int gap);
    int n, emit;
    bit drop, crc_bad, len_bad, rxe;
    bit [47:0] da;
    bit [31:0] rx_fcs;
    exp_t e;
    n = fr.size();
    drop = 1'b0;
`ifdef RGMII_RX_MAC_FILTER_EN
    if (n >= 6) begin
      da = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
      drop = (da != MAC) && (da != 48'hFFFF_FFFF_FFFF);
    end
`endif
    if (!drop) begin
      if (n > MAX_LEN) begin
        emit = MAX_LEN - 4;
        crc_bad = 1'b0;
        len_bad = 1'b1;
        rxe = (er_idx >= 0) && (er_idx <= MAX_LEN);
      end else begin
        emit = (n > 4) ? n - 4 : 0;
        rx_fcs = {fr[n-1], fr[n-2], fr[n-3], fr[n-4]};
        crc_bad = (fcs32(n - 4) != rx_fcs);
        len_bad = (n < MIN_LEN) || (n > MAX_LEN);
        rxe = (er_idx >= 0) && (er_idx < n);
      end
      for (int i = 0; i < emit; i++) push_byte(fr[i], i == 0);
      if ({crc_bad, len_bad, rxe} == 3'b000) exp_ok++; else exp_bad++;
      e = '{eof: 1'b1, data: 8'h00, sof: 1'b0, err: {crc_bad, len_bad, rxe}, ok: exp_ok, bad: exp_bad};
      sb.push_back(e);
    end
    for (int i = 0; i < pre; i++) drv(1'b1, 1'b0, 8'h55);
    drv(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < n; i++) drv(1'b1, i == er_idx, fr[i]);
    for (int i = 0; i < gap; i++) drv(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    rx_data = 8'h00;
    rx_ctl = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_eof", int'(out_eof), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_frames_ok", int'(frames_ok), 0);
    chk("rst_frames_bad", int'(frames_bad), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // good 64-byte frame, bad FCS, rx_er mid-frame, back-to-back with 1-cycle gaps
    build(60, 0); add_fcs(1'b0); send_frame(7, -1, 1);
    build(60, 0); add_fcs(1'b1); send_frame(7, -1, 1);
    build(60, 0); add_fcs(1'b0); send_frame(7, 20, 1);
    // length boundaries: one under minimum, exactly four bytes, exactly maximum
    build(59, 1); add_fcs(1'b0); send_frame(3, -1, 1);
    build(0, 1);  add_fcs(1'b0); send_frame(1, -1, 2);
    build(MAX_LEN - 4, 1); add_fcs(1'b0); send_frame(7, -1, 2);
    // oversize frame then a good one
    build(1596, 0); add_fcs(1'b0); send_frame(7, -1, 3);
    build(60, 1); add_fcs(1'b0); send_frame(0, -1, 1);
    drain();

    // bad preamble and false carrier produce nothing
    drv(1'b1, 1'b0, 8'h55); drv(1'b1, 1'b0, 8'h55); drv(1'b1, 1'b0, 8'h12);
    for (int i = 0; i < 20; i++) drv(1'b1, 1'b0, 8'(i));
    drv(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) drv(1'b0, 1'b1, 8'h0F);
    drv(1'b0, 1'b0, 8'h00);
    drain();
    chk("badpre_frames_ok", int'(frames_ok), exp_ok);
    chk("badpre_frames_bad", int'(frames_bad), exp_bad);

    // destination address cases: station, broadcast, other
    build(60, 1); for (int i = 0; i < 6; i++) fr[i] = MAC[47-8*i -: 8]; add_fcs(1'b0); send_frame(7, -1, 1);
    build(60, 1); for (int i = 0; i < 6; i++) fr[i] = 8'hFF;            add_fcs(1'b0); send_frame(7, -1, 1);
    build(60, 1); fr[0] = 8'h04;                                        add_fcs(1'b0); send_frame(7, -1, 1);
    drain();

    // randomized frames
    for (int k = 0; k < 16; k++) begin
      int len, er_idx;
      len = $urandom_range(0, 90);
      build(len, 1);
      if ($urandom_range(0, 3) == 0) begin
        fr[0] = 8'hFF; fr[1] = 8'hFF; fr[2] = 8'hFF; fr[3] = 8'hFF; fr[4] = 8'hFF; fr[5] = 8'hFF;
      end
      add_fcs($urandom_range(0, 2) == 0);
      er_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len + 3) : -1;
      send_frame($urandom_range(0, 7), er_idx, $urandom_range(1, 3));
    end
    drain();

    // reset in the middle of DATA: no eof, everything cleared
    for (int i = 0; i < 7; i++) drv(1'b1, 1'b0, 8'h55);
    drv(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 3; i++) drv(1'b1, 1'b0, 8'(i));
    @(negedge clk);
    reset = 1'b1;
    rx_ctl = 2'b00;
    repeat (2) @(negedge clk);
    exp_ok = 0;
    exp_bad = 0;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_eof", int'(out_eof), 0);
    chk("midrst_frames_ok", int'(frames_ok), 0);
    chk("midrst_frames_bad", int'(frames_bad), 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) drv(1'b1, 1'b0, 8'(i + 8'h40));
    drv(1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    build(60, 0); for (int i = 0; i < 6; i++) fr[i] = 8'hFF; add_fcs(1'b0); send_frame(7, -1, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
